atm_host_driver: RTL and testbench

- Initiator-side driver for the ATM controller: turns one host transaction request (PIN, amount, type) into the controller's card/digit/amount stimulus.
- Sequence: asserts card presence, serialises the 4-digit BCD PIN as digit strobes, presents the amount with a strobe, then collects the controller's response flags into one result code.
- Sits between a host/keypad model and the ATM controller; it is also the reusable stimulus engine for system tests.

---
 rtl/atm_pkg.sv | 52 +++++
 rtl/atm_wait_timer.sv | 30 +++
 rtl/atm_host_driver.sv | 197 +++++++++++++++++++
 tb/tb_atm_host_driver.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM host driver.
//   - atm_state_e  : driver FSM states
//   - atm_result_e : outcome codes reported on result
//   - TT_*         : transaction type encodings
//   - pin helpers  : BCD format check and digit selection (digit 0 = pin[15:12])
package atm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCard,
    StSendDigit,
    StGap,
    StWaitPin,
    StSendAmount,
    StWaitResult,
    StFinish
  } atm_state_e;

  typedef enum logic [2:0] {
    ResOkDeposit  = 3'd0,
    ResOkWithdraw = 3'd1,
    ResWrongPin   = 3'd2,
    ResBlocked    = 3'd3,
    ResNoFunds    = 3'd4,
    ResTimeout    = 3'd5,
    ResBadFmt     = 3'd6
  } atm_result_e;

  localparam logic TT_DEPOSIT  = 1'b0;
  localparam logic TT_WITHDRAW = 1'b1;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [1:0]  LastDigitIdx = 2'(NUM_DIGITS - 1);

  // True when every nibble is a valid BCD digit.
  function automatic logic pin_fmt_ok(input logic [15:0] pin);
    return (pin[15:12] <= 4'd9) && (pin[11:8] <= 4'd9) &&
           (pin[7:4]   <= 4'd9) && (pin[3:0]  <= 4'd9);
  endfunction

  function automatic logic [3:0] pin_digit(input logic [15:0] pin, input logic [1:0] idx);
    logic [3:0] d;
    case (idx)
      2'd0:    d = pin[15:12];
      2'd1:    d = pin[11:8];
      2'd2:    d = pin[7:4];
      default: d = pin[3:0];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/atm_wait_timer.sv
// Loadable down-counter shared by the digit gap, PIN wait and response timeout.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load         : load load_value on this edge (takes priority over counting)
//   load_value   : value to load
//   zero         : count is zero (the last cycle of the timed interval)
module atm_wait_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/atm_host_driver.sv
// Initiator-side driver for the ATM controller. One accepted start runs:
// card present -> four BCD digit strobes -> PIN rejection window -> amount strobe
// -> response collection -> one-cycle done with a result code.
//   start, pin_code, amount_in, trans_type_in : host request (start sampled in idle only)
//   received_card, trans_type, std_digit, digit, stb_amount, amount : controller stimulus
//   balance_updated, give_money, incorrect_pin, insufficient_funds, warning, block :
//     controller responses
//   busy, done, result, warn_seen : host status
// Parameters must be >= 1 except DIGIT_GAP, which may be 0 (back-to-back strobes).
module atm_host_driver
  import atm_pkg::*;
#(
  parameter int unsigned DIGIT_GAP    = 2,
  parameter int unsigned PIN_WAIT     = 8,
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pin_code,
  input  logic [31:0] amount_in,
  input  logic        trans_type_in,
  output logic        received_card,
  output logic        trans_type,
  output logic        std_digit,
  output logic [3:0]  digit,
  output logic        stb_amount,
  output logic [31:0] amount,
  input  logic        balance_updated,
  input  logic        give_money,
  input  logic        incorrect_pin,
  input  logic        insufficient_funds,
  input  logic        warning,
  input  logic        block,
  output logic        busy,
  output logic        done,
  output logic [2:0]  result,
  output logic        warn_seen
);

  localparam int unsigned MaxGapPin = (DIGIT_GAP + 1 > PIN_WAIT) ? DIGIT_GAP + 1 : PIN_WAIT;
  localparam int unsigned CntMax    = (MaxGapPin > RESP_TIMEOUT) ? MaxGapPin : RESP_TIMEOUT;
  localparam int unsigned CntW      = $clog2(CntMax + 1);

  // Loaded one below the interval length: the count==0 cycle is the interval's last.
  localparam logic [CntW-1:0] GapLoad  = CntW'((DIGIT_GAP > 0) ? DIGIT_GAP - 1 : 0);
  localparam logic [CntW-1:0] PinLoad  = CntW'((PIN_WAIT > 0) ? PIN_WAIT - 1 : 0);
  localparam logic [CntW-1:0] RespLoad = CntW'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);

  atm_state_e  state_q, state_d;
  atm_result_e res_d;
  logic [15:0] pin_q;
  logic [1:0]  idx_q;

  logic            timer_load;
  logic [CntW-1:0] timer_value;
  logic            timer_zero;

  // Next state, and the result code to report when entering StFinish.
  always_comb begin
    state_d = state_q;
    res_d   = ResOkDeposit;
    case (state_q)
      StIdle: begin
        if (start && pin_fmt_ok(pin_code)) state_d = StCard;
      end
      StCard: state_d = StSendDigit;
      StSendDigit: begin
        if (idx_q == LastDigitIdx) state_d = StWaitPin;
        else if (DIGIT_GAP != 0)   state_d = StGap;
      end
      StGap: begin
        if (timer_zero) state_d = StSendDigit;
      end
      StWaitPin: begin
        if (block) begin
          state_d = StFinish;
          res_d   = ResBlocked;
        end else if (incorrect_pin) begin
          state_d = StFinish;
          res_d   = ResWrongPin;
        end else if (timer_zero) begin
          state_d = StSendAmount;
        end
      end
      StSendAmount: state_d = StWaitResult;
      StWaitResult: begin
        if (insufficient_funds) begin
          state_d = StFinish;
          res_d   = ResNoFunds;
        end else if (trans_type == TT_WITHDRAW && give_money) begin
          state_d = StFinish;
          res_d   = ResOkWithdraw;
        end else if (trans_type == TT_DEPOSIT && balance_updated) begin
          state_d = StFinish;
          res_d   = ResOkDeposit;
        end else if (timer_zero) begin
          state_d = StFinish;
          res_d   = ResTimeout;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Timer reloads on every state change with the duration of the state being entered.
  always_comb begin
    timer_load  = (state_d != state_q);
    timer_value = '0;
    case (state_d)
      StGap:        timer_value = GapLoad;
      StWaitPin:    timer_value = PinLoad;
      StWaitResult: timer_value = RespLoad;
      default:      timer_value = '0;
    endcase
  end

  atm_wait_timer #(
    .Width (CntW)
  ) u_wait_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      pin_q         <= '0;
      idx_q         <= '0;
      received_card <= 1'b0;
      trans_type    <= 1'b0;
      std_digit     <= 1'b0;
      digit         <= '0;
      stb_amount    <= 1'b0;
      amount        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      warn_seen     <= 1'b0;
    end else begin
      state_q    <= state_d;
      std_digit  <= 1'b0;
      stb_amount <= 1'b0;
      done       <= 1'b0;

      if (state_q != StIdle && warning) warn_seen <= 1'b1;

      case (state_q)
        StIdle: begin
          if (start) begin
            if (pin_fmt_ok(pin_code)) begin
              pin_q         <= pin_code;
              amount        <= amount_in;
              trans_type    <= trans_type_in;
              idx_q         <= '0;
              busy          <= 1'b1;
              received_card <= 1'b1;
              warn_seen     <= 1'b0;
              result        <= ResOkDeposit;
            end else begin
              result <= ResBadFmt;
              done   <= 1'b1;
            end
          end
        end
        StCard: begin
          std_digit <= 1'b1;
          digit     <= pin_digit(pin_q, 2'd0);
        end
        StSendDigit, StGap: begin
          // Next strobe is issued on the edge that re-enters StSendDigit.
          if (state_d == StSendDigit) begin
            std_digit <= 1'b1;
            digit     <= pin_digit(pin_q, idx_q + 2'd1);
            idx_q     <= idx_q + 2'd1;
          end
        end
        StWaitPin: begin
          if (state_d == StSendAmount) stb_amount <= 1'b1;
        end
        default: ;
      endcase

      if (state_d == StFinish) begin
        received_card <= 1'b0;
        busy          <= 1'b0;
        done          <= 1'b1;
        result        <= res_d;
      end
    end
  end

endmodule

// File: tb/tb_atm_host_driver.sv
// Directed bench for atm_host_driver. Cycle numbers are relative to the cycle in
// which start is held high (cycle 0); outputs are sampled on the falling edge.
module tb_atm_host_driver;

  localparam int unsigned DigitGap    = 2;
  localparam int unsigned PinWait     = 8;
  localparam int unsigned RespTimeout = 10;

  localparam int ModeNone     = 0;
  localparam int ModeBalUpd   = 1;
  localparam int ModeNoFunds  = 2;
  localparam int ModeWrongPin = 3;
  localparam int ModeBlockPin = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pin_code;
  logic [31:0] amount_in;
  logic        trans_type_in;
  logic        received_card, trans_type, std_digit, stb_amount;
  logic [3:0]  digit;
  logic [31:0] amount;
  logic        balance_updated, give_money, incorrect_pin, insufficient_funds, warning, block;
  logic        busy, done, warn_seen;
  logic [2:0]  result;

  atm_host_driver #(
    .DIGIT_GAP    (DigitGap),
    .PIN_WAIT     (PinWait),
    .RESP_TIMEOUT (RespTimeout)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .pin_code           (pin_code),
    .amount_in          (amount_in),
    .trans_type_in      (trans_type_in),
    .received_card      (received_card),
    .trans_type         (trans_type),
    .std_digit          (std_digit),
    .digit              (digit),
    .stb_amount         (stb_amount),
    .amount             (amount),
    .balance_updated    (balance_updated),
    .give_money         (give_money),
    .incorrect_pin      (incorrect_pin),
    .insufficient_funds (insufficient_funds),
    .warning            (warning),
    .block              (block),
    .busy               (busy),
    .done               (done),
    .result             (result),
    .warn_seen          (warn_seen)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Per-transaction record, cycles relative to the start cycle.
  int          strobe_cyc[4];
  logic [3:0]  strobe_dig[4];
  int          n_strobe, n_stb_amt, stb_amt_cyc, n_done, done_cyc, card_first, txn_t;
  logic [31:0] stb_amt_val;
  logic        stb_tt, done_card, done_busy, done_warn, warn_t1;
  logic [2:0]  done_res;

  task automatic clear_flags();
    balance_updated    = 1'b0;
    give_money         = 1'b0;
    incorrect_pin      = 1'b0;
    insufficient_funds = 1'b0;
    warning            = 1'b0;
    block              = 1'b0;
  endtask

  // Runs one request; the controller model answers per mode, dly cycles after its
  // trigger (amount strobe, or the 4th digit strobe for PIN responses).
  task automatic run_txn(input logic [15:0] pin, input logic [31:0] amt, input logic tt,
                         input int mode, input int dly, input int warn_at,
                         input int busy_start_at, input int rst_at);
    int c;
    n_strobe = 0; n_stb_amt = 0; stb_amt_cyc = -1; n_done = 0; done_cyc = -1;
    card_first = -1; warn_t1 = 1'bx;
    @(negedge clock);
    txn_t         = cyc;
    pin_code      = pin;
    amount_in     = amt;
    trans_type_in = tt;
    start         = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      c     = cyc - txn_t;
      start = 1'b0;
      if (c == busy_start_at) begin
        start    = 1'b1;
        pin_code = 16'hFFFF;
      end
      if (std_digit) begin
        if (n_strobe < 4) begin
          strobe_cyc[n_strobe] = c;
          strobe_dig[n_strobe] = digit;
        end
        n_strobe++;
      end
      if (stb_amount) begin
        n_stb_amt++;
        stb_amt_cyc = c;
        stb_amt_val = amount;
        stb_tt      = trans_type;
      end
      if (received_card && card_first < 0) card_first = c;
      if (c == 1) warn_t1 = warn_seen;
      if (done) begin
        n_done++;
        done_cyc  = c;
        done_res  = result;
        done_card = received_card;
        done_busy = busy;
        done_warn = warn_seen;
      end
      if (rst_at >= 0 && c == rst_at + 1) begin
        check_eq("mid reset outputs zero",
                 {received_card, trans_type, std_digit, digit, stb_amount, amount,
                  busy, done, result, warn_seen}, '0);
      end
      reset = (rst_at >= 0 && c == rst_at);
      clear_flags();
      balance_updated    = (mode == ModeBalUpd && n_stb_amt > 0 && c == stb_amt_cyc + dly);
      insufficient_funds = (mode == ModeNoFunds && n_stb_amt > 0 && c == stb_amt_cyc + dly);
      give_money         = insufficient_funds;
      incorrect_pin      = ((mode == ModeWrongPin || mode == ModeBlockPin) && n_strobe == 4 &&
                            c == strobe_cyc[3] + dly);
      block              = (mode == ModeBlockPin) && incorrect_pin;
      warning            = (c == warn_at);
      if (done && rst_at < 0) break;
    end
    clear_flags();
    start = 1'b0;
    reset = 1'b0;
  endtask

  int spurious;

  initial begin
    reset = 1'b1; start = 1'b0; pin_code = '0; amount_in = '0; trans_type_in = 1'b0;
    clear_flags();
    repeat (3) @(negedge clock);
    check_eq("reset outputs zero",
             {received_card, trans_type, std_digit, digit, stb_amount, amount,
              done, result, warn_seen}, '0);
    check_eq("reset busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);

    // Deposit 1234 / 500: strobes 2,5,8,11; PIN window 12..19; amount strobe 20;
    // balance_updated at 23 -> done at 24.
    run_txn(16'h1234, 32'd500, 1'b0, ModeBalUpd, 3, -1, -1, -1);
    check_eq("dep card first", card_first, 1);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("dep strobe%0d cycle", k), strobe_cyc[k], 2 + 3 * k);
      check_eq($sformatf("dep strobe%0d digit", k), strobe_dig[k], k + 1);
    end
    check_eq("dep strobe count", n_strobe, 4);
    check_eq("dep amount strobes", n_stb_amt, 1);
    check_eq("dep amount cycle", stb_amt_cyc, 20);
    check_eq("dep amount value", stb_amt_val, 500);
    check_eq("dep done cycle", done_cyc, 24);
    check_eq("dep result", done_res, 0);
    check_eq("dep card in done", done_card, 0);
    check_eq("dep busy in done", done_busy, 0);
    @(negedge clock);
    check_eq("dep done one cycle", done, 0);
    check_eq("dep busy after", busy, 0);
    check_eq("dep result held", result, 0);

    // Withdrawal with insufficient_funds and give_money together -> NO_FUNDS.
    run_txn(16'h4321, 32'd100, 1'b1, ModeNoFunds, 2, -1, -1, -1);
    check_eq("nofunds amount", stb_amt_val, 100);
    check_eq("nofunds trans_type", stb_tt, 1);
    check_eq("nofunds result", done_res, 4);
    check_eq("nofunds done cycle", done_cyc, 23);

    // incorrect_pin two cycles after the 4th strobe (cycle 13) -> done at 14.
    run_txn(16'h0007, 32'd42, 1'b0, ModeWrongPin, 2, -1, -1, -1);
    check_eq("wrongpin result", done_res, 2);
    check_eq("wrongpin done cycle", done_cyc, 14);
    check_eq("wrongpin no amount", n_stb_amt, 0);
    check_eq("wrongpin card in done", done_card, 0);

    // block and incorrect_pin in the same cycle -> BLOCKED wins.
    run_txn(16'h0007, 32'd42, 1'b0, ModeBlockPin, 2, -1, -1, -1);
    check_eq("blocked result", done_res, 3);

    // Non-BCD nibble: immediate BAD_FMT, nothing driven to the controller.
    run_txn(16'h12A4, 32'd9, 1'b0, ModeNone, 0, -1, -1, -1);
    check_eq("badfmt result", done_res, 6);
    check_eq("badfmt done cycle", done_cyc, 1);
    check_eq("badfmt busy", done_busy, 0);
    check_eq("badfmt no card", card_first, -1);
    check_eq("badfmt no strobes", n_strobe + n_stb_amt, 0);
    spurious = 0;
    repeat (20) begin
      @(negedge clock);
      if (received_card || std_digit || stb_amount || busy) spurious++;
    end
    check_eq("badfmt quiet afterwards", spurious, 0);

    // Withdrawal without response: 10 cycles in WAIT_RESULT (21..30) -> done at 31.
    run_txn(16'h5678, 32'd77, 1'b1, ModeNone, 0, 6, -1, -1);
    check_eq("timeout result", done_res, 5);
    check_eq("timeout done cycle", done_cyc, stb_amt_cyc + 11);
    check_eq("warn_seen at done", done_warn, 1);
    repeat (3) @(negedge clock);
    check_eq("warn_seen sticky", warn_seen, 1);

    // Deposit with a bad-format start while busy: must be ignored.
    run_txn(16'h9870, 32'd5, 1'b0, ModeBalUpd, 1, -1, 5, -1);
    check_eq("restart warn cleared", warn_t1, 0);
    check_eq("busystart digit0", strobe_dig[0], 9);
    check_eq("busystart digit1", strobe_dig[1], 8);
    check_eq("busystart digit2", strobe_dig[2], 7);
    check_eq("busystart digit3", strobe_dig[3], 0);
    check_eq("busystart done count", n_done, 1);
    check_eq("busystart result", done_res, 0);
    check_eq("busystart done cycle", done_cyc, 22);

    // Reset during the 3rd digit gap (cycle 9): zeros at 10, no done afterwards.
    run_txn(16'h5555, 32'd1, 1'b0, ModeBalUpd, 1, -1, -1, 9);
    check_eq("reset strobe count", n_strobe, 3);
    check_eq("reset no done", n_done, 0);
    check_eq("reset no amount", n_stb_amt, 0);
    check_eq("reset busy after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
